vanilla_sb_release_monitor: RTL and testbench
=============================================

Name: vanilla_sb_release_monitor

Overview:
Testbench monitor at the release end of the vanilla core's long-latency scoreboard. It consumes per-register scoreboard set events (issue of idiv, fdiv/fsqrt, remote load or amo) and clear events (writeback release) for the int and float register files. It pairs each clear with its outstanding set and reports per-completion latency, running max latency and completion count. It flags spurious clears, double sets and timeouts. It sits beside the core in the manycore testbench and is passive: it drives nothing back into the core.

Parameters:
- ctr_width_p, 16, width of the per-register age counters, latency outputs and max-latency outputs. Saturating.
- count_width_p, 32, width of the completion counters.
- timeout_p, 4096, age at or above which a pending register is reported as timed out. Must be less than 2^ctr_width_p.
- reg_els_lp, RV32_reg_els_gp (32), registers per file.
- reg_addr_width_lp, RV32_reg_addr_width_gp (5), register id width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- int_set_i  in  1  int scoreboard set event this cycle (already qualified by ~stall_id, ~stall_all, ~flush).
- int_set_id_i  in  5  rd being scoreboarded.
- int_clear_i  in  1  int scoreboard clear event.
- int_clear_id_i  in  5  rd being released.
- float_set_i, float_set_id_i, float_clear_i, float_clear_id_i  in  1/5/1/5  float-file equivalents.
- int_done_v_o  out  1  pulse: int completion reported.
- int_done_id_o  out  5  id of that completion.
- int_done_lat_o  out  ctr_width_p  latency of that completion.
- float_done_v_o, float_done_id_o, float_done_lat_o  out  1/5/ctr_width_p  float equivalents.
- int_pending_o, float_pending_o  out  32  current pending bitmaps.
- int_timeout_o, float_timeout_o  out  32  per-register: pending and age >= timeout_p.
- int_max_lat_o, float_max_lat_o  out  ctr_width_p  largest latency reported since reset.
- int_count_o, float_count_o  out  count_width_p  completions since reset. Wrap at 2^count_width_p.
- err_spurious_clear_o  out  1  pulse: clear arrived on a non-pending register, either file.
- err_double_set_o  out  1  pulse: set arrived on a pending register that is not being cleared the same cycle.
- err_sticky_o  out  1  OR of all error pulses since reset.

Behaviour:
- Reset:
  - All pending bits, ages, max, count, done_v, error pulses and err_sticky_o are 0 on the cycle after reset_i is sampled high.
  - Reset mid-operation discards outstanding entries silently.
  - Events presented while reset_i is high are ignored.
- Int register x0: set or clear with id 0 is ignored entirely (no state change, no error). f0 is a normal register.
- Set at cycle t: pending[id]=1 and age[id]=1 in cycle t+1.
- Age: each cycle pending and not cleared, age increments, saturating at all-ones.
- Clear at cycle t on a pending id:
  - In cycle t+1: done_v=1, done_id=id, done_lat=age[id] as sampled in cycle t.
  - pending clears, count increments, max updates if lat > max.
  - Set at t and clear at t+1 reports latency 1.
  - Latency is therefore the number of cycles from the set-event cycle to the clear-event cycle.
- Set and clear on the same id in the same cycle, id pending:
  - The old entry completes and is reported.
  - The new entry starts with age 1.
  - No error.
- Set and clear on the same id in the same cycle, id not pending: spurious clear error; the set still takes effect.
- Set and clear on different ids in the same cycle: both are handled independently.
- Errors:
  - err_spurious_clear_o and err_double_set_o are registered one-cycle pulses (cycle t+1); int and float causes are ORed.
  - On a double set the age restarts at 1.
  - On a spurious clear no done pulse is produced.
- Timeout: timeout outputs derive only from registered state. A bit rises in the cycle age reaches timeout_p and falls when the entry clears.
- All done/error outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package: vanilla_sb_release_monitor_pkg, holding a typedef vanilla_sb_entry_s {pending, age[ctr_width_p]} and the error-cause enum (spurious_clear, double_set). It belongs beside vanilla_scoreboard_tracker_pkg.
- One sub-module, vanilla_sb_release_file, instanced twice (int, float) with an ignore_reg0_p parameter (1 for int, 0 for float). It holds the 32 entries, the done/max/count registers and per-file error pulses. The top ORs the per-file errors and keeps err_sticky_o.

Test Plan:
- int set id 5 at cycle 10, clear id 5 at cycle 17 -> int_done_v_o=1, id=5, lat=7 at cycle 18; int_count_o=1; int_max_lat_o=7; int_pending_o=0.
- float set id 0 at cycle 3, clear id 0 at cycle 4 -> float_done_lat_o=1 at cycle 5; int set id 0 -> no pending bit, no error.
- int clear id 9 with nothing pending -> err_spurious_clear_o pulse next cycle, no done pulse, err_sticky_o stays 1.
- int set id 3 at cycle 0, then set+clear id 3 at cycle 4 -> done lat=4 at cycle 5; id 3 still pending with age 1; no error. Clear id 3 at cycle 6 -> lat=2.
- timeout_p=8: float set id 12 held 9 cycles -> float_timeout_o[12]=1 from cycle 8 after set; clear -> bit drops cycle after clear; lat=9.
- int set id 7 pending, assert reset_i at cycle 5 -> all outputs 0 at cycle 6; later clear id 7 -> err_spurious_clear_o.

Source files
------------

// File: rtl/vanilla_sb_release_monitor_pkg.sv
// rtl/vanilla_sb_release_monitor_pkg.sv - shared types for the scoreboard release monitor
// Purpose: register-file geometry, the scoreboard entry record and the error-cause enum.
// Ports: none (package).
package vanilla_sb_release_monitor_pkg;

  localparam int sb_reg_els_gp        = 32;
  localparam int sb_reg_addr_width_gp = 5;
  localparam int sb_ctr_width_gp      = 16;

  // Canonical shape of one scoreboard entry at the default counter width.
  typedef struct packed {
    logic                       pending;
    logic [sb_ctr_width_gp-1:0] age;
  } vanilla_sb_entry_s;

  // Error causes; the value doubles as the bit index in per-file error vectors.
  typedef enum logic [0:0] {
    e_sb_err_spurious_clear = 1'b0,
    e_sb_err_double_set     = 1'b1
  } vanilla_sb_err_e;

  localparam int sb_err_els_gp = 2;

endpackage

// File: rtl/vanilla_sb_release_file.sv
// rtl/vanilla_sb_release_file.sv - per-register-file scoreboard set/clear tracker
// Purpose: tracks 32 pending entries with saturating ages, reports completions,
//          running max latency, completion count and per-file error pulses.
// Ports: clk_i/reset_i; set_i/set_id_i, clear_i/clear_id_i events;
//        done_v_o/done_id_o/done_lat_o completion report; pending_o, timeout_o
//        bitmaps; max_lat_o, count_o statistics; err_o pulses indexed by vanilla_sb_err_e.
module vanilla_sb_release_file
  import vanilla_sb_release_monitor_pkg::*;
#(
  parameter int ctr_width_p   = 16,
  parameter int count_width_p = 32,
  parameter int timeout_p     = 4096,
  parameter bit ignore_reg0_p = 1'b0
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            set_i,
  input  logic [sb_reg_addr_width_gp-1:0] set_id_i,
  input  logic                            clear_i,
  input  logic [sb_reg_addr_width_gp-1:0] clear_id_i,
  output logic                            done_v_o,
  output logic [sb_reg_addr_width_gp-1:0] done_id_o,
  output logic [ctr_width_p-1:0]          done_lat_o,
  output logic [sb_reg_els_gp-1:0]        pending_o,
  output logic [sb_reg_els_gp-1:0]        timeout_o,
  output logic [ctr_width_p-1:0]          max_lat_o,
  output logic [count_width_p-1:0]        count_o,
  output logic [sb_err_els_gp-1:0]        err_o
);

  localparam logic [ctr_width_p-1:0] timeout_lp = ctr_width_p'(timeout_p);

  logic [sb_reg_els_gp-1:0]        pending_q, pending_d;
  logic [ctr_width_p-1:0]          age_q [sb_reg_els_gp];
  logic [ctr_width_p-1:0]          age_d [sb_reg_els_gp];
  logic                            done_v_q, done_v_d;
  logic [sb_reg_addr_width_gp-1:0] done_id_q, done_id_d;
  logic [ctr_width_p-1:0]          done_lat_q, done_lat_d;
  logic [ctr_width_p-1:0]          max_q, max_d;
  logic [count_width_p-1:0]        count_q, count_d;
  logic [sb_err_els_gp-1:0]        err_q, err_d;

  logic set_v, clr_v, clr_hit;

  always_comb begin
    // x0 is hardwired; its events are dropped before any bookkeeping.
    set_v   = set_i & ~(ignore_reg0_p & (set_id_i == '0));
    clr_v   = clear_i & ~(ignore_reg0_p & (clear_id_i == '0));
    clr_hit = clr_v & pending_q[clear_id_i];

    err_d = '0;
    err_d[e_sb_err_spurious_clear] = clr_v & ~pending_q[clear_id_i];
    // A set on a pending id is legal when that id is released the same cycle.
    err_d[e_sb_err_double_set] = set_v & pending_q[set_id_i]
                                 & ~(clr_v & (clear_id_i == set_id_i));

    for (int i = 0; i < sb_reg_els_gp; i++) begin
      pending_d[i] = pending_q[i];
      age_d[i]     = age_q[i];
      if (pending_q[i] && (age_q[i] != '1)) age_d[i] = age_q[i] + 1'b1;
      if (clr_hit && (clear_id_i == sb_reg_addr_width_gp'(i))) begin
        pending_d[i] = 1'b0;
        age_d[i]     = '0;
      end
      // Set last so that a same-cycle set restarts the entry after the release.
      if (set_v && (set_id_i == sb_reg_addr_width_gp'(i))) begin
        pending_d[i] = 1'b1;
        age_d[i]     = ctr_width_p'(1);
      end
    end

    done_v_d   = clr_hit;
    done_id_d  = clear_id_i;
    done_lat_d = age_q[clear_id_i];
    max_d      = (clr_hit && (age_q[clear_id_i] > max_q)) ? age_q[clear_id_i] : max_q;
    count_d    = count_q + count_width_p'(clr_hit);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q  <= '0;
      for (int i = 0; i < sb_reg_els_gp; i++) age_q[i] <= '0;
      done_v_q   <= 1'b0;
      done_id_q  <= '0;
      done_lat_q <= '0;
      max_q      <= '0;
      count_q    <= '0;
      err_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      for (int i = 0; i < sb_reg_els_gp; i++) age_q[i] <= age_d[i];
      done_v_q   <= done_v_d;
      done_id_q  <= done_id_d;
      done_lat_q <= done_lat_d;
      max_q      <= max_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < sb_reg_els_gp; i++) begin
      timeout_o[i] = pending_q[i] & (age_q[i] >= timeout_lp);
    end
  end

  assign done_v_o   = done_v_q;
  assign done_id_o  = done_id_q;
  assign done_lat_o = done_lat_q;
  assign pending_o  = pending_q;
  assign max_lat_o  = max_q;
  assign count_o    = count_q;
  assign err_o      = err_q;

endmodule

// File: rtl/vanilla_sb_release_monitor.sv
// rtl/vanilla_sb_release_monitor.sv - passive long-latency scoreboard release monitor
// Purpose: pairs scoreboard set/clear events per register for the int and float
//          files, reporting latency, max latency, counts, timeouts and errors.
// Ports: clk_i/reset_i; int_/float_ set/clear events with ids; per-file done
//        report, pending/timeout bitmaps, max latency and count; combined
//        err_spurious_clear_o / err_double_set_o pulses and err_sticky_o.
module vanilla_sb_release_monitor
  import vanilla_sb_release_monitor_pkg::*;
#(
  parameter int ctr_width_p   = 16,
  parameter int count_width_p = 32,
  parameter int timeout_p     = 4096
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            int_set_i,
  input  logic [sb_reg_addr_width_gp-1:0] int_set_id_i,
  input  logic                            int_clear_i,
  input  logic [sb_reg_addr_width_gp-1:0] int_clear_id_i,
  input  logic                            float_set_i,
  input  logic [sb_reg_addr_width_gp-1:0] float_set_id_i,
  input  logic                            float_clear_i,
  input  logic [sb_reg_addr_width_gp-1:0] float_clear_id_i,
  output logic                            int_done_v_o,
  output logic [sb_reg_addr_width_gp-1:0] int_done_id_o,
  output logic [ctr_width_p-1:0]          int_done_lat_o,
  output logic                            float_done_v_o,
  output logic [sb_reg_addr_width_gp-1:0] float_done_id_o,
  output logic [ctr_width_p-1:0]          float_done_lat_o,
  output logic [sb_reg_els_gp-1:0]        int_pending_o,
  output logic [sb_reg_els_gp-1:0]        float_pending_o,
  output logic [sb_reg_els_gp-1:0]        int_timeout_o,
  output logic [sb_reg_els_gp-1:0]        float_timeout_o,
  output logic [ctr_width_p-1:0]          int_max_lat_o,
  output logic [ctr_width_p-1:0]          float_max_lat_o,
  output logic [count_width_p-1:0]        int_count_o,
  output logic [count_width_p-1:0]        float_count_o,
  output logic                            err_spurious_clear_o,
  output logic                            err_double_set_o,
  output logic                            err_sticky_o
);

  logic [sb_err_els_gp-1:0] int_err, float_err;
  logic                     sticky_q;

  vanilla_sb_release_file #(
    .ctr_width_p(ctr_width_p), .count_width_p(count_width_p),
    .timeout_p(timeout_p), .ignore_reg0_p(1'b1)
  ) int_file (
    .clk_i(clk_i), .reset_i(reset_i),
    .set_i(int_set_i), .set_id_i(int_set_id_i),
    .clear_i(int_clear_i), .clear_id_i(int_clear_id_i),
    .done_v_o(int_done_v_o), .done_id_o(int_done_id_o), .done_lat_o(int_done_lat_o),
    .pending_o(int_pending_o), .timeout_o(int_timeout_o),
    .max_lat_o(int_max_lat_o), .count_o(int_count_o), .err_o(int_err)
  );

  vanilla_sb_release_file #(
    .ctr_width_p(ctr_width_p), .count_width_p(count_width_p),
    .timeout_p(timeout_p), .ignore_reg0_p(1'b0)
  ) float_file (
    .clk_i(clk_i), .reset_i(reset_i),
    .set_i(float_set_i), .set_id_i(float_set_id_i),
    .clear_i(float_clear_i), .clear_id_i(float_clear_id_i),
    .done_v_o(float_done_v_o), .done_id_o(float_done_id_o), .done_lat_o(float_done_lat_o),
    .pending_o(float_pending_o), .timeout_o(float_timeout_o),
    .max_lat_o(float_max_lat_o), .count_o(float_count_o), .err_o(float_err)
  );

  assign err_spurious_clear_o = int_err[e_sb_err_spurious_clear] | float_err[e_sb_err_spurious_clear];
  assign err_double_set_o     = int_err[e_sb_err_double_set] | float_err[e_sb_err_double_set];

  always_ff @(posedge clk_i) begin
    if (reset_i) sticky_q <= 1'b0;
    else         sticky_q <= sticky_q | err_spurious_clear_o | err_double_set_o;
  end

  // Include the live pulses so the sticky flag rises together with the first error.
  assign err_sticky_o = sticky_q | err_spurious_clear_o | err_double_set_o;

endmodule

// File: tb/tb_vanilla_sb_release_monitor.sv
// tb/tb_vanilla_sb_release_monitor.sv - directed table-driven bench for the release monitor
module tb_vanilla_sb_release_monitor;
  import vanilla_sb_release_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        int_set_i = 0, int_clear_i = 0, float_set_i = 0, float_clear_i = 0;
  logic [4:0]  int_set_id_i = 0, int_clear_id_i = 0, float_set_id_i = 0, float_clear_id_i = 0;
  logic        int_done_v_o, float_done_v_o;
  logic [4:0]  int_done_id_o, float_done_id_o;
  logic [15:0] int_done_lat_o, float_done_lat_o, int_max_lat_o, float_max_lat_o;
  logic [31:0] int_pending_o, float_pending_o, int_timeout_o, float_timeout_o;
  logic [31:0] int_count_o, float_count_o;
  logic        err_spurious_clear_o, err_double_set_o, err_sticky_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vanilla_sb_release_monitor #(.ctr_width_p(16), .count_width_p(32), .timeout_p(8)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .int_set_i(int_set_i), .int_set_id_i(int_set_id_i),
    .int_clear_i(int_clear_i), .int_clear_id_i(int_clear_id_i),
    .float_set_i(float_set_i), .float_set_id_i(float_set_id_i),
    .float_clear_i(float_clear_i), .float_clear_id_i(float_clear_id_i),
    .int_done_v_o(int_done_v_o), .int_done_id_o(int_done_id_o), .int_done_lat_o(int_done_lat_o),
    .float_done_v_o(float_done_v_o), .float_done_id_o(float_done_id_o),
    .float_done_lat_o(float_done_lat_o),
    .int_pending_o(int_pending_o), .float_pending_o(float_pending_o),
    .int_timeout_o(int_timeout_o), .float_timeout_o(float_timeout_o),
    .int_max_lat_o(int_max_lat_o), .float_max_lat_o(float_max_lat_o),
    .int_count_o(int_count_o), .float_count_o(float_count_o),
    .err_spurious_clear_o(err_spurious_clear_o), .err_double_set_o(err_double_set_o),
    .err_sticky_o(err_sticky_o)
  );

  typedef struct {
    logic        is;  logic [4:0] isid; logic ic; logic [4:0] icid;
    logic        fs;  logic [4:0] fsid; logic fc; logic [4:0] fcid;
    logic        idv; logic [4:0] iid;  logic [15:0] ilat;
    logic        fdv; logic [4:0] fid;  logic [15:0] flat;
    logic        spur; logic dbl;
    logic [31:0] ipend; logic [31:0] fpend;
  } vec_t;

  localparam int n_vec = 13;
  vec_t vecs [n_vec];

  function automatic vec_t mk(int is, int isid, int ic, int icid,
                              int fs, int fsid, int fc, int fcid,
                              int idv, int iid, int ilat, int fdv, int fid, int flat,
                              int spur, int dbl, int ipend, int fpend);
    vec_t v;
    v.is = 1'(is);   v.isid = 5'(isid); v.ic = 1'(ic); v.icid = 5'(icid);
    v.fs = 1'(fs);   v.fsid = 5'(fsid); v.fc = 1'(fc); v.fcid = 5'(fcid);
    v.idv = 1'(idv); v.iid = 5'(iid);   v.ilat = 16'(ilat);
    v.fdv = 1'(fdv); v.fid = 5'(fid);   v.flat = 16'(flat);
    v.spur = 1'(spur); v.dbl = 1'(dbl);
    v.ipend = 32'(ipend); v.fpend = 32'(fpend);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    int_set_i = 0; int_clear_i = 0; float_set_i = 0; float_clear_i = 0;
    int_set_id_i = 0; int_clear_id_i = 0; float_set_id_i = 0; float_clear_id_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  vanilla_sb_entry_s exp_e;

  initial begin
    //          is isid ic icid fs fsid fc fcid idv iid ilat fdv fid flat spur dbl ipend  fpend
    vecs[0]  = mk(1, 5, 0, 0,  0, 0,  0, 0,   0, 0, 0,  0, 0, 0,  0, 0, 'h20, 'h0);
    vecs[1]  = mk(0, 0, 0, 0,  1, 0,  0, 0,   0, 0, 0,  0, 0, 0,  0, 0, 'h20, 'h1);
    vecs[2]  = mk(1, 0, 0, 0,  0, 0,  1, 0,   0, 0, 0,  1, 0, 1,  0, 0, 'h20, 'h0);
    vecs[3]  = mk(0, 0, 1, 9,  0, 0,  0, 0,   0, 0, 0,  0, 0, 0,  1, 0, 'h20, 'h0);
    vecs[4]  = mk(1, 3, 0, 0,  1, 4,  0, 0,   0, 0, 0,  0, 0, 0,  0, 0, 'h28, 'h10);
    vecs[5]  = mk(1, 3, 0, 0,  0, 0,  0, 0,   0, 0, 0,  0, 0, 0,  0, 1, 'h28, 'h10);
    vecs[6]  = mk(0, 0, 1, 5,  0, 0,  0, 0,   1, 5, 6,  0, 0, 0,  0, 0, 'h08, 'h10);
    vecs[7]  = mk(1, 3, 1, 3,  0, 0,  0, 0,   1, 3, 2,  0, 0, 0,  0, 0, 'h08, 'h10);
    vecs[8]  = mk(0, 0, 0, 0,  1, 4,  1, 4,   0, 0, 0,  1, 4, 4,  0, 0, 'h08, 'h10);
    vecs[9]  = mk(0, 0, 0, 0,  1, 7,  1, 7,   0, 0, 0,  0, 0, 0,  1, 0, 'h08, 'h90);
    vecs[10] = mk(0, 0, 1, 3,  0, 0,  0, 0,   1, 3, 3,  0, 0, 0,  0, 0, 'h00, 'h90);
    vecs[11] = mk(1, 0, 1, 0,  0, 0,  0, 0,   0, 0, 0,  0, 0, 0,  0, 0, 'h00, 'h90);
    vecs[12] = mk(0, 0, 0, 0,  0, 0,  1, 0,   0, 0, 0,  0, 0, 0,  1, 0, 'h00, 'h90);

    // Reset state
    do_reset();
    chk("rst_int_pending", int_pending_o, 0);
    chk("rst_float_pending", float_pending_o, 0);
    chk("rst_int_done_v", 32'(int_done_v_o), 0);
    chk("rst_float_done_v", 32'(float_done_v_o), 0);
    chk("rst_int_count", int_count_o, 0);
    chk("rst_float_max", 32'(float_max_lat_o), 0);
    chk("rst_sticky", 32'(err_sticky_o), 0);
    chk("rst_timeout", int_timeout_o | float_timeout_o, 0);

    // Table of one-cycle event vectors, results sampled in the following cycle
    for (int k = 0; k < n_vec; k++) begin
      int_set_i = vecs[k].is;     int_set_id_i = vecs[k].isid;
      int_clear_i = vecs[k].ic;   int_clear_id_i = vecs[k].icid;
      float_set_i = vecs[k].fs;   float_set_id_i = vecs[k].fsid;
      float_clear_i = vecs[k].fc; float_clear_id_i = vecs[k].fcid;
      tick();
      chk($sformatf("v%0d_int_done_v", k), 32'(int_done_v_o), 32'(vecs[k].idv));
      if (vecs[k].idv) begin
        chk($sformatf("v%0d_int_done_id", k), 32'(int_done_id_o), 32'(vecs[k].iid));
        chk($sformatf("v%0d_int_done_lat", k), 32'(int_done_lat_o), 32'(vecs[k].ilat));
      end
      chk($sformatf("v%0d_float_done_v", k), 32'(float_done_v_o), 32'(vecs[k].fdv));
      if (vecs[k].fdv) begin
        chk($sformatf("v%0d_float_done_id", k), 32'(float_done_id_o), 32'(vecs[k].fid));
        chk($sformatf("v%0d_float_done_lat", k), 32'(float_done_lat_o), 32'(vecs[k].flat));
      end
      chk($sformatf("v%0d_spurious", k), 32'(err_spurious_clear_o), 32'(vecs[k].spur));
      chk($sformatf("v%0d_double_set", k), 32'(err_double_set_o), 32'(vecs[k].dbl));
      chk($sformatf("v%0d_int_pending", k), int_pending_o, vecs[k].ipend);
      chk($sformatf("v%0d_float_pending", k), float_pending_o, vecs[k].fpend);
    end
    idle_inputs();

    chk("int_count", int_count_o, 3);
    chk("int_max_lat", 32'(int_max_lat_o), 6);
    chk("float_count", float_count_o, 2);
    chk("float_max_lat", 32'(float_max_lat_o), 4);
    chk("sticky_after_table", 32'(err_sticky_o), 1);
    chk("no_timeout_short", int_timeout_o | float_timeout_o, 0);

    // Timeout rises when age reaches 8, drops after the clear, latency 9
    do_reset();
    chk("sticky_cleared", 32'(err_sticky_o), 0);
    float_set_i = 1; float_set_id_i = 12;
    tick();
    idle_inputs();
    exp_e.pending = 1'b1;
    exp_e.age = 16'd1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("timeout_age%0d", k), 32'(float_timeout_o[12]),
          32'(exp_e.pending && (exp_e.age >= 16'd8)));
      tick();
      exp_e.age = exp_e.age + 16'd1;
    end
    chk("timeout_age9", 32'(float_timeout_o[12]), 1);
    float_clear_i = 1; float_clear_id_i = 12;
    tick();
    idle_inputs();
    chk("timeout_cleared", 32'(float_timeout_o[12]), 0);
    chk("timeout_done_v", 32'(float_done_v_o), 1);
    chk("timeout_done_id", 32'(float_done_id_o), 12);
    chk("timeout_done_lat", 32'(float_done_lat_o), 32'(exp_e.age));
    chk("timeout_max_lat", 32'(float_max_lat_o), 9);

    // Reset mid-operation drops outstanding entries and ignores events under reset
    int_set_i = 1; int_set_id_i = 7;
    tick();
    idle_inputs();
    tick();
    chk("midrst_pre_pending", int_pending_o, 32'h80);
    reset_i = 1'b1;
    int_set_i = 1; int_set_id_i = 8;
    tick();
    reset_i = 1'b0;
    idle_inputs();
    chk("midrst_int_pending", int_pending_o, 0);
    chk("midrst_float_max", 32'(float_max_lat_o), 0);
    chk("midrst_float_count", float_count_o, 0);
    chk("midrst_sticky", 32'(err_sticky_o), 0);
    int_clear_i = 1; int_clear_id_i = 7;
    tick();
    idle_inputs();
    chk("midrst_spurious", 32'(err_spurious_clear_o), 1);
    chk("midrst_no_done", 32'(int_done_v_o), 0);
    chk("midrst_sticky_set", 32'(err_sticky_o), 1);
    tick();
    chk("midrst_pulse_ends", 32'(err_spurious_clear_o), 0);
    chk("midrst_sticky_holds", 32'(err_sticky_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
